// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the instruction-ROM bus, the decode-side output buffer handshake
//   and the downstream control inputs (redirect, halt) of fetch_sequencer.
//
// Signals
//   imem_addr        fetch -> ROM      byte address (= pc)
//   imem_instr       ROM -> fetch      combinational ROM data for imem_addr
//   redirect_valid   ctrl -> fetch     branch/JR taken this cycle
//   redirect_target  ctrl -> fetch     new PC when redirect_valid
//   halt_req         ctrl -> fetch     stop fetching after the current capture
//   inst_valid       fetch -> decode   inst_out/inst_pc hold a live entry
//   inst_ready       decode -> fetch   decode consumes the entry this cycle
//   inst_out         fetch -> decode   registered instruction word
//   inst_pc          fetch -> decode   address the word was fetched from
//   halted           fetch -> ctrl     1 while the sequencer is halted
//
// Handshake: an entry transfers on a cycle where inst_valid & inst_ready are
// both high at the rising edge. While inst_valid is high and inst_ready is
// low, inst_out/inst_pc stay stable. inst_valid never depends
// combinationally on inst_ready.
//
// modport master: the fetch sequencer.  modport slave: ROM/decode/control.

interface fetch_sequencer_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        halted;

   modport master (
      output imem_addr, inst_valid, inst_out, inst_pc, halted,
      input  imem_instr, redirect_valid, redirect_target, halt_req, inst_ready
   );

   modport slave (
      input  imem_addr, inst_valid, inst_out, inst_pc, halted,
      output imem_instr, redirect_valid, redirect_target, halt_req, inst_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the PC of the MIPS core, drives the combinational instruction ROM
//   and registers each fetched word into a one-entry output buffer toward
//   decode. J/JAL are pre-decoded so their target is fetched with no bubble.
//   Redirects (branch/JR resolved downstream) and a halt request are accepted.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   bus        ---  fetch_sequencer_if.master (ROM bus, decode handshake,
//                   redirect/halt control, halted status)
//   state_dbg  out  current FSM state (0 BOOT, 1 RUN, 2 HALTED)

module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   fetch_sequencer_if.master   bus,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] npc;
   logic        inst_valid_q;
   logic [31:0] inst_out_q;
   logic [31:0] inst_pc_q;
   logic        redirect;
   logic        capture;
   logic        is_jump;

   assign pc4     = pc + 32'd4;
   assign is_jump = (bus.imem_instr[31:26] == 6'h02) ||
                    (bus.imem_instr[31:26] == 6'h03);

   // J/JAL target is formed from the word being captured so the next fetch
   // already lands on the target; there is no delay slot.
   always_comb begin
      npc = pc4;
      if (is_jump)
         npc = {pc4[31:28], bus.imem_instr[25:0], 2'b00};
   end

   // Redirects are ignored while booting.
   assign redirect = bus.redirect_valid && (state != BOOT);
   // A redirect in the same cycle suppresses capture of the wrong-path word.
   assign capture  = (state == RUN) && (!inst_valid_q || bus.inst_ready) &&
                     !bus.redirect_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_out_q   <= 32'h0;
         inst_pc_q    <= 32'h0;
      end else begin
         if (state == BOOT) begin
            state <= RUN;
         end else if (redirect) begin
            // Buffered word is discarded even if decode is taking it now.
            pc           <= bus.redirect_target & 32'hFFFF_FFFC;
            inst_valid_q <= 1'b0;
            state        <= RUN;
         end else if (capture) begin
            inst_out_q   <= bus.imem_instr;
            inst_pc_q    <= pc;
            inst_valid_q <= 1'b1;
            pc           <= npc;
            if (bus.halt_req)
               state <= HALTED;
         end else if (inst_valid_q && bus.inst_ready) begin
            // Only reachable in HALTED: drain the last entry.
            inst_valid_q <= 1'b0;
         end
      end
   end

   assign bus.imem_addr  = pc;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst_out   = inst_out_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.halted     = (state == HALTED);
   assign state_dbg      = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed table of per-cycle inputs and expected outputs for
//   fetch_sequencer, followed by hand-written reset-mid-stall and
//   redirect-during-boot sequences.

module tb_fetch_sequencer;

   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;
   int         n_vec;
   int         n_fail;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- ROM model ----------------
   // 0x04: JAL 3 (-> 0x0C); 0x30: J 0x10 (-> 0x40); other low words are
   // ADDI with the address in the immediate; everything else reads as 0.
   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h04)       return 32'h0C00_0003;
      else if (a == 32'h30)  return 32'h0800_0010;
      else if (a < 32'h100)  return 32'h2000_0000 | a;
      else                   return 32'h0;
   endfunction

   always_comb bus.imem_instr = rom(bus.imem_addr);

   // ---------------- checker ----------------
   task automatic check(input string name, input int idx,
                        input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic check_out(input int idx, input logic v, input logic [31:0] p,
                            input logic [31:0] o, input logic [31:0] a,
                            input logic h);
      check("inst_valid", idx, {31'b0, bus.inst_valid}, {31'b0, v});
      check("inst_pc",    idx, bus.inst_pc, p);
      check("inst_out",   idx, bus.inst_out, o);
      check("imem_addr",  idx, bus.imem_addr, a);
      check("halted",     idx, {31'b0, bus.halted}, {31'b0, h});
   endtask

   task automatic drive(input logic rv, input logic [31:0] rt,
                        input logic hr, input logic rdy);
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      bus.halt_req        = hr;
      bus.inst_ready      = rdy;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rv;
      logic [31:0] rt;
      logic        hr;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eout;
      logic [31:0] eaddr;
      logic        eh;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   initial begin
      n_vec  = 0;
      n_fail = 0;

      // Expected values are outputs #1 after the edge that samples the row's inputs.
      //           rv   rt             hr   rdy   v    inst_pc        inst_out       imem_addr      halted
      vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,         32'h0,         1'b0}; // BOOT
      vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h2000_0000, 32'h4,         1'b0};
      vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,        32'h0C00_0003, 32'hC,         1'b0}; // JAL
      vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hC,        32'h2000_000C, 32'h10,        1'b0};
      vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        32'h2000_000C, 32'h10,        1'b0}; // stall
      vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        32'h2000_000C, 32'h10,        1'b0};
      vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        32'h2000_000C, 32'h10,        1'b0};
      vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10,       32'h2000_0010, 32'h14,        1'b0};
      vecs[8]  = '{1'b1, 32'h2B,       1'b0, 1'b1, 1'b0, 32'h10,       32'h2000_0010, 32'h28,        1'b0}; // redirect
      vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h28,       32'h2000_0028, 32'h2C,        1'b0};
      vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2C,       32'h2000_002C, 32'h30,        1'b0};
      vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h30,       32'h0800_0010, 32'h40,        1'b0}; // J
      vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h40,       32'h2000_0040, 32'h44,        1'b0};
      vecs[13] = '{1'b1, 32'h18,       1'b0, 1'b1, 1'b0, 32'h40,       32'h2000_0040, 32'h18,        1'b0};
      vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h18,       32'h2000_0018, 32'h1C,        1'b1}; // halt
      vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h18,       32'h2000_0018, 32'h1C,        1'b1};
      vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h18,       32'h2000_0018, 32'h1C,        1'b1}; // drain
      vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h18,       32'h2000_0018, 32'h1C,        1'b1};
      vecs[18] = '{1'b1, 32'h24,       1'b0, 1'b1, 1'b0, 32'h18,       32'h2000_0018, 32'h24,        1'b0}; // resume
      vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h24,       32'h2000_0024, 32'h28,        1'b0};
      vecs[20] = '{1'b1, 32'h50,       1'b1, 1'b1, 1'b0, 32'h24,       32'h2000_0024, 32'h50,        1'b0}; // rv beats hr
      vecs[21] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h50,       32'h2000_0050, 32'h54,        1'b0};
      vecs[22] = '{1'b1, 32'hFFFF_FFFC,1'b0, 1'b1, 1'b0, 32'h50,       32'h2000_0050, 32'hFFFF_FFFC, 1'b0};
      vecs[23] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC,32'h0,         32'h0,         1'b0}; // wrap
      vecs[24] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h2000_0000, 32'h4,         1'b0};

      // ---------------- reset ----------------
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      #2;
      check_out(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("state_dbg", -1, {30'b0, state_dbg}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rv, vecs[i].rt, vecs[i].hr, vecs[i].rdy);
         @(posedge clk);
         #1;
         check_out(i, vecs[i].ev, vecs[i].epc, vecs[i].eout, vecs[i].eaddr, vecs[i].eh);
      end

      // ---------------- reset asserted mid-stall ----------------
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_out(100, 1'b1, 32'h0, 32'h2000_0000, 32'h4, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_out(101, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("state_dbg", 101, {30'b0, state_dbg}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // ---------------- redirect during BOOT is ignored ----------------
      drive(1'b1, 32'h80, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_out(102, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      check("state_dbg", 102, {30'b0, state_dbg}, 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_out(103, 1'b1, 32'h0, 32'h2000_0000, 32'h4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
